// File: rtl/multicycle_control_unit_if.sv
// Instruction-memory fetch port: request/valid handshake between the control unit
// (master) and the program memory (slave).
interface multicycle_control_unit_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [31:0]     imem_rdata;

   modport master (output imem_req, imem_addr, input  imem_valid, imem_rdata);
   modport slave  (input  imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE control unit: fetches instructions over a
// request/valid port, drives datapath controls and resolves flag-conditional branches.
module multicycle_control_unit #(
   parameter int          DATA_W   = 16,
   parameter int          REG_AW   = 3,
   parameter int          PC_W     = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   multicycle_control_unit_if.master imem,
   input  logic                   zero_flag,
   input  logic                   pos_flag,
   output logic [REG_AW-1:0]      rs_addr,
   output logic [REG_AW-1:0]      rt_addr,
   output logic [REG_AW-1:0]      rd_addr,
   output logic [DATA_W-1:0]      imm_data,
   output logic [3:0]             alu_sel,
   output logic                   imm_sel,
   output logic                   rf_write,
   output logic                   mem_write,
   output logic [PC_W-1:0]        pc,
   output logic                   halted,
   output logic                   illegal_op
);

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0, OP_ALU, OP_ALUI, OP_LI, OP_ST, OP_BZ, OP_BP, OP_JMP, OP_HALT
   } opcode_e;

   state_t          state;
   logic [3:0]      opcode;
   logic            flag_z;
   logic            flag_p;
   logic            req_q;
   logic            writes_rf;
   logic            take_branch;
   logic [PC_W-1:0] branch_off;
   logic            unused_rd_bits;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc;

   // Only the low REG_AW bits of each register byte are meaningful.
   assign unused_rd_bits = ^imem.imem_rdata[23:16];

   // Size cast of a signed operand sign-extends (or truncates) the branch offset to PC_W.
   assign branch_off = PC_W'($signed(imm_data[15:0]));

   // NOTE: every always_comb output gets a default before the case, so no latch is inferred.
   always_comb begin
      writes_rf   = 1'b0;
      take_branch = 1'b0;
      case (opcode)
         OP_ALU, OP_ALUI, OP_LI: writes_rf   = 1'b1;
         OP_BZ:                  take_branch = flag_z;
         OP_BP:                  take_branch = flag_p;
         OP_JMP:                 take_branch = 1'b1;
         default:                ;
      endcase
   end

   // NOTE: all state and registered outputs clear asynchronously, so strobes and imem_req
   // drop the instant reset_n falls rather than waiting for a clock edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_FETCH;
         pc         <= PC_W'(RESET_PC);
         opcode     <= OP_NOP;
         flag_z     <= 1'b0;
         flag_p     <= 1'b0;
         req_q      <= 1'b0;
         rs_addr    <= '0;
         rt_addr    <= '0;
         rd_addr    <= '0;
         imm_data   <= '0;
         alu_sel    <= 4'h0;
         imm_sel    <= 1'b0;
         rf_write   <= 1'b0;
         mem_write  <= 1'b0;
         illegal_op <= 1'b0;
         halted     <= 1'b0;
      end else begin
         // NOTE: strobes default low each cycle so they can only ever be one cycle wide.
         rf_write   <= 1'b0;
         mem_write  <= 1'b0;
         illegal_op <= 1'b0;
         case (state)
            S_FETCH: begin
               if (!req_q) begin
                  req_q <= 1'b1;
               end else if (imem.imem_valid) begin
                  req_q    <= 1'b0;
                  opcode   <= imem.imem_rdata[31:28];
                  rd_addr  <= imem.imem_rdata[16 +: REG_AW];
                  rs_addr  <= imem.imem_rdata[8 +: REG_AW];
                  rt_addr  <= imem.imem_rdata[0 +: REG_AW];
                  imm_data <= DATA_W'($signed(imem.imem_rdata[15:0]));
                  case (imem.imem_rdata[31:28])
                     OP_ALU: begin
                        alu_sel <= imem.imem_rdata[27:24];
                        imm_sel <= 1'b0;
                     end
                     OP_ALUI: begin
                        alu_sel <= imem.imem_rdata[27:24];
                        imm_sel <= 1'b1;
                     end
                     OP_LI: begin
                        alu_sel <= 4'hF;
                        imm_sel <= 1'b1;
                     end
                     default: begin
                        alu_sel <= 4'h0;
                        imm_sel <= 1'b0;
                     end
                  endcase
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               rf_write   <= writes_rf;
               mem_write  <= (opcode == OP_ST);
               illegal_op <= (opcode > OP_HALT);
               state      <= S_EXECUTE;
            end
            S_EXECUTE: begin
               // Flags are captured only from ALU-producing instructions.
               if (writes_rf) begin
                  flag_z <= zero_flag;
                  flag_p <= pos_flag;
               end
               if (opcode == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  pc    <= take_branch ? pc + branch_off : pc + PC_W'(1);
                  req_q <= 1'b1;
                  state <= S_FETCH;
               end
            end
            S_HALT:  ;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: table of instructions with hand-derived expected controls,
// a scoreboard queue between fetch handshake and EXECUTE, plus halt and reset-abort sequences.
module tb_multicycle_control_unit;

   typedef struct {
      logic [31:0] instr;
      logic        zf;
      logic        pf;
      int          waits;
      logic        rf;
      logic        mw;
      logic        ill;
      logic [2:0]  rd;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [15:0] imm;
      logic [3:0]  alu;
      logic        isel;
      logic [7:0]  npc;
   } vec_t;

   localparam int NV = 17;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        zero_flag, pos_flag;
   logic [2:0]  rs_addr, rt_addr, rd_addr;
   logic [15:0] imm_data;
   logic [3:0]  alu_sel;
   logic        imm_sel, rf_write, mem_write, halted, illegal_op;
   logic [7:0]  pc;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_pc;
   vec_t        vecs [NV];
   vec_t        sb_q [$];

   multicycle_control_unit_if #(.PC_W(8)) imem ();

   multicycle_control_unit #(
      .DATA_W(16), .REG_AW(3), .PC_W(8), .RESET_PC(0)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .imem       (imem),
      .zero_flag  (zero_flag),
      .pos_flag   (pos_flag),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rd_addr    (rd_addr),
      .imm_data   (imm_data),
      .alu_sel    (alu_sel),
      .imm_sel    (imm_sel),
      .rf_write   (rf_write),
      .mem_write  (mem_write),
      .pc         (pc),
      .halted     (halted),
      .illegal_op (illegal_op)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_fields(input vec_t v, input string ph);
      check({ph, "_rd"},      rd_addr,  v.rd);
      check({ph, "_rs"},      rs_addr,  v.rs);
      check({ph, "_rt"},      rt_addr,  v.rt);
      check({ph, "_imm"},     imm_data, v.imm);
      check({ph, "_alu_sel"}, alu_sel,  v.alu);
      check({ph, "_imm_sel"}, imm_sel,  v.isel);
   endtask

   // Entered at a negedge in FETCH with imem_req expected high; leaves at the negedge after EXECUTE.
   task automatic run_vec(input vec_t v);
      vec_t exp;
      logic is_halt;
      is_halt = (v.instr[31:28] == 4'h8);
      check("fetch_addr", imem.imem_addr, exp_pc);
      check("fetch_req",  imem.imem_req,  1'b1);
      for (int w = 0; w < v.waits; w++) begin
         imem.imem_valid = 1'b0;
         @(negedge clock);
         check("wait_addr",    imem.imem_addr, exp_pc);
         check("wait_req",     imem.imem_req,  1'b1);
         check("wait_strobes", {rf_write, mem_write, illegal_op}, 3'b000);
      end
      imem.imem_valid = 1'b1;
      imem.imem_rdata = v.instr;
      sb_q.push_back(v);
      @(negedge clock);
      // Valid during DECODE/EXECUTE must be ignored.
      imem.imem_rdata = $urandom;
      check("dec_req",     imem.imem_req, 1'b0);
      check("dec_strobes", {rf_write, mem_write, illegal_op}, 3'b000);
      check_fields(v, "dec");
      zero_flag = v.zf;
      pos_flag  = v.pf;
      @(negedge clock);
      exp = sb_q.pop_front();
      check("exe_rf_write",   rf_write,   exp.rf);
      check("exe_mem_write",  mem_write,  exp.mw);
      check("exe_illegal_op", illegal_op, exp.ill);
      check("exe_pc",         pc,         exp_pc);
      check_fields(exp, "exe");
      @(negedge clock);
      imem.imem_valid = 1'b0;
      exp_pc = exp.npc;
      check("next_pc",      pc,             exp_pc);
      check("next_halted",  halted,         is_halt);
      check("next_req",     imem.imem_req,  !is_halt);
      check("next_strobes", {rf_write, mem_write, illegal_op}, 3'b000);
   endtask

   initial begin
      //           instr         zf pf w  rf mw il rd rs rt imm      alu   is npc
      vecs[0]  = '{32'h30010005, 0, 1, 0, 1, 0, 0, 1, 0, 5, 16'h0005, 4'hF, 1, 8'd1};
      vecs[1]  = '{32'h3002FFFF, 0, 0, 2, 1, 0, 0, 2, 7, 7, 16'hFFFF, 4'hF, 1, 8'd2};
      vecs[2]  = '{32'h00000000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 0, 8'd3};
      vecs[3]  = '{32'h11020101, 1, 0, 0, 1, 0, 0, 2, 1, 1, 16'h0101, 4'h1, 0, 8'd4};
      vecs[4]  = '{32'h5000FFFF, 0, 0, 0, 0, 0, 0, 0, 7, 7, 16'hFFFF, 4'h0, 0, 8'd3};
      vecs[5]  = '{32'h11020103, 0, 1, 0, 1, 0, 0, 2, 1, 3, 16'h0103, 4'h1, 0, 8'd4};
      vecs[6]  = '{32'h5000FFFF, 0, 0, 0, 0, 0, 0, 0, 7, 7, 16'hFFFF, 4'h0, 0, 8'd5};
      vecs[7]  = '{32'h60000003, 0, 0, 0, 0, 0, 0, 0, 0, 3, 16'h0003, 4'h0, 0, 8'd8};
      vecs[8]  = '{32'h2004FFFE, 0, 0, 1, 1, 0, 0, 4, 7, 6, 16'hFFFE, 4'h0, 1, 8'd9};
      vecs[9]  = '{32'h60000005, 0, 0, 0, 0, 0, 0, 0, 0, 5, 16'h0005, 4'h0, 0, 8'd10};
      vecs[10] = '{32'h40000203, 1, 1, 0, 0, 1, 0, 0, 2, 3, 16'h0203, 4'h0, 0, 8'd11};
      vecs[11] = '{32'h50000002, 0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h0002, 4'h0, 0, 8'd12};
      vecs[12] = '{32'hC0000000, 1, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 4'h0, 0, 8'd13};
      vecs[13] = '{32'h700000F2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h00F2, 4'h0, 0, 8'd255};
      vecs[14] = '{32'h70000001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 4'h0, 0, 8'd0};
      vecs[15] = '{32'h70000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 0, 8'd0};
      vecs[16] = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 0, 8'd0};

      reset_n         = 1'b0;
      imem.imem_valid = 1'b0;
      imem.imem_rdata = 32'h0;
      zero_flag       = 1'b0;
      pos_flag        = 1'b0;
      #3;
      check("rst_req",     imem.imem_req,  1'b0);
      check("rst_addr",    imem.imem_addr, 8'd0);
      check("rst_pc",      pc,             8'd0);
      check("rst_strobes", {rf_write, mem_write, illegal_op, halted}, 4'b0000);
      check("rst_fields",  {rd_addr, rs_addr, rt_addr, imm_data, alu_sel, imm_sel}, 30'd0);

      @(negedge clock);
      reset_n = 1'b1;
      #1 check("req_before_edge", imem.imem_req, 1'b0);
      @(negedge clock);
      check("req_first_edge", imem.imem_req, 1'b1);

      exp_pc = 8'd0;
      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Halted core ignores the memory and stays put.
      for (int i = 0; i < 4; i++) begin
         imem.imem_valid = 1'b1;
         imem.imem_rdata = vecs[0].instr;
         @(negedge clock);
         check("halt_halted",  halted,        1'b1);
         check("halt_req",     imem.imem_req, 1'b0);
         check("halt_pc",      pc,            8'd0);
         check("halt_strobes", {rf_write, mem_write, illegal_op}, 3'b000);
      end
      imem.imem_valid = 1'b0;

      // Reset out of HALT, run LI to pc 1, then abort the next LI in EXECUTE.
      reset_n = 1'b0;
      #1;
      check("rst2_halted", halted,        1'b0);
      check("rst2_req",    imem.imem_req, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      exp_pc = 8'd0;
      run_vec(vecs[0]);
      check("abort_pre_pc", pc, 8'd1);
      imem.imem_valid = 1'b1;
      imem.imem_rdata = vecs[1].instr;
      @(negedge clock);
      imem.imem_valid = 1'b0;
      @(negedge clock);
      check("abort_rf_write_before", rf_write, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_rf_write", rf_write,       1'b0);
      check("abort_req",      imem.imem_req,  1'b0);
      check("abort_pc",       pc,             8'd0);
      check("abort_rd",       rd_addr,        3'd0);
      check("abort_imm_sel",  imm_sel,        1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      #1 check("abort_req_released", imem.imem_req, 1'b0);
      @(negedge clock);
      exp_pc = 8'd0;
      run_vec(vecs[0]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
